hazard_fwd_5: RTL and testbench

- Hazard-detection and forwarding-control unit for the 5-stage MIPS pipeline.
- Consumes the 5-bit destination register number chosen in ID (rt/rd select) plus write/load flags, and carries them through internal EX/MEM/WB slots.
- Compares each decoded source register against older in-flight destinations. Produces a load-use stall, registered forwarding-mux selects for EX, and the write-back register number/enable for the register-file write port.

---
 rtl/hazard_fwd_5.sv | 128 ++++++++++++
 tb/tb_hazard_fwd_5.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_5.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// Ports: ID decode info in, load-use stall, EX forward selects, WB reg/enable out.
module hazard_fwd_5 #(
  parameter int RW = 5,
  parameter int FW = 2
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [RW-1:0] id_wreg,
  input  logic          id_we,
  input  logic          id_load,
  input  logic          flush,
  output logic          stall,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [RW-1:0] wb_wreg,
  output logic          wb_we
);

  localparam logic [FW-1:0] F_RF  = FW'(0);
  localparam logic [FW-1:0] F_MEM = FW'(1);
  localparam logic [FW-1:0] F_WB  = FW'(2);
  localparam logic [FW-1:0] F_DLY = FW'(3);

  logic [RW-1:0] r_ex_wreg;
  logic          r_ex_we;
  logic          r_ex_ld;
  logic [RW-1:0] r_mem_wreg;
  logic          r_mem_we;
  logic [RW-1:0] r_wb_wreg;
  logic          r_wb_we;
  logic [FW-1:0] r_fwd_a;
  logic [FW-1:0] r_fwd_b;

  logic          w_rs_nz;
  logic          w_rt_nz;
  logic          w_ex_a;
  logic          w_mem_a;
  logic          w_wb_a;
  logic          w_ex_b;
  logic          w_mem_b;
  logic          w_wb_b;
  logic          w_stall;
  logic          w_kill;
  logic [FW-1:0] w_code_a;
  logic [FW-1:0] w_code_b;

  // $zero is never a forwarding source
  assign w_rs_nz = id_use_rs && (id_rs != '0);
  assign w_rt_nz = id_use_rt && (id_rt != '0);

  assign w_ex_a  = w_rs_nz && r_ex_we  && (r_ex_wreg  == id_rs);
  assign w_mem_a = w_rs_nz && r_mem_we && (r_mem_wreg == id_rs);
  assign w_wb_a  = w_rs_nz && r_wb_we  && (r_wb_wreg  == id_rs);
  assign w_ex_b  = w_rt_nz && r_ex_we  && (r_ex_wreg  == id_rt);
  assign w_mem_b = w_rt_nz && r_mem_we && (r_mem_wreg == id_rt);
  assign w_wb_b  = w_rt_nz && r_wb_we  && (r_wb_wreg  == id_rt);

  // a load result is not ready for EX-to-EX forwarding
  assign w_stall = id_valid && !flush && r_ex_ld
                && (w_ex_a || w_ex_b);
  assign w_kill  = w_stall || flush;

  // youngest producer wins
  always_comb begin
    w_code_a = F_RF;
    priority case (1'b1)
      w_ex_a:  w_code_a = F_MEM;
      w_mem_a: w_code_a = F_WB;
      w_wb_a:  w_code_a = F_DLY;
      default: w_code_a = F_RF;
    endcase
  end

  always_comb begin
    w_code_b = F_RF;
    priority case (1'b1)
      w_ex_b:  w_code_b = F_MEM;
      w_mem_b: w_code_b = F_WB;
      w_wb_b:  w_code_b = F_DLY;
      default: w_code_b = F_RF;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_ex_wreg  <= '0;
      r_ex_we    <= 1'b0;
      r_ex_ld    <= 1'b0;
      r_mem_wreg <= '0;
      r_mem_we   <= 1'b0;
      r_wb_wreg  <= '0;
      r_wb_we    <= 1'b0;
      r_fwd_a    <= F_RF;
      r_fwd_b    <= F_RF;
    end else begin
      if (w_kill) begin
        r_ex_wreg <= '0;
        r_ex_we   <= 1'b0;
        r_ex_ld   <= 1'b0;
        r_fwd_a   <= F_RF;
        r_fwd_b   <= F_RF;
      end else begin
        r_ex_wreg <= id_wreg;
        r_ex_we   <= id_we && id_valid;
        r_ex_ld   <= id_load && id_valid;
        r_fwd_a   <= id_valid ? w_code_a : F_RF;
        r_fwd_b   <= id_valid ? w_code_b : F_RF;
      end
      r_mem_wreg <= r_ex_wreg;
      r_mem_we   <= r_ex_we;
      r_wb_wreg  <= r_mem_wreg;
      r_wb_we    <= r_mem_we;
    end
  end

  assign stall   = w_stall;
  assign fwd_a   = r_fwd_a;
  assign fwd_b   = r_fwd_b;
  assign wb_wreg = r_wb_wreg;
  assign wb_we   = r_wb_we;

endmodule

// File: tb/tb_hazard_fwd_5.sv
// Scoreboard bench for hazard_fwd_5: random and directed instruction streams
// checked against a history-based reference model.
module tb_hazard_fwd_5;

  logic       clk = 1'b0;
  logic       rstd;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic       id_use_rs, id_use_rt, id_we, id_load, flush;
  logic       stall, wb_we;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] wb_wreg;

  always #5 clk = ~clk;

  hazard_fwd_5 dut (
    .clk(clk), .rstd(rstd), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_we(id_we), .id_load(id_load),
    .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_wreg(wb_wreg), .wb_we(wb_we)
  );

  typedef struct {
    logic [4:0] wreg;
    logic       we;
    logic       ld;
  } slot_t;

  typedef struct {
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] wr;
    logic       we;
  } exp_t;

  // h[0] = most recently issued (EX), h[1] = MEM, h[2] = WB
  slot_t      h [3];
  logic [1:0] m_fa, m_fb;
  exp_t       q [$];
  int         errors = 0;
  int         checks = 0;
  logic       last_st;

  function automatic logic hit(int i, logic [4:0] r, logic u);
    return u && r != 0 && h[i].we && h[i].wreg == r;
  endfunction

  // age of the youngest matching producer: 1, 2, 3, or 0 for none
  function automatic logic [1:0] code(logic [4:0] r, logic u);
    for (int i = 0; i < 3; i++)
      if (hit(i, r, u)) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    return id_valid && !flush && h[0].ld
        && (hit(0, id_rs, id_use_rs) || hit(0, id_rt, id_use_rt));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) h[i] = '{5'd0, 1'b0, 1'b0};
    m_fa = 2'd0;
    m_fb = 2'd0;
  endtask

  task automatic m_edge();
    slot_t n;
    logic  k;
    logic [1:0] ca, cb;
    if (!rstd) begin
      m_reset();
      return;
    end
    k  = m_stall() || flush;
    ca = code(id_rs, id_use_rs);
    cb = code(id_rt, id_use_rt);
    if (k) n = '{5'd0, 1'b0, 1'b0};
    else   n = '{id_wreg, id_we && id_valid, id_load && id_valid};
    m_fa = (k || !id_valid) ? 2'd0 : ca;
    m_fb = (k || !id_valid) ? 2'd0 : cb;
    h[2] = h[1];
    h[1] = h[0];
    h[0] = n;
  endtask

  task automatic push_exp();
    exp_t e;
    if (!rstd) m_reset();
    e.st = m_stall();
    e.fa = m_fa;
    e.fb = m_fb;
    e.wr = h[2].wreg;
    e.we = h[2].we;
    last_st = e.st;
    q.push_back(e);
  endtask

  task automatic cyc(input logic rn, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] wr, input logic we,
                     input logic ld, input logic fl);
    @(posedge clk);
    m_edge();
    #1;
    rstd = rn; id_valid = v; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; id_wreg = wr;
    id_we = we; id_load = ld; flush = fl;
    push_exp();
  endtask

  // issue one instruction, holding it while the model says it stalls
  task automatic ins(input logic [4:0] wr, input logic we,
                     input logic ld, input logic [4:0] rs,
                     input logic urs, input logic [4:0] rt,
                     input logic urt);
    int n = 0;
    cyc(1, 1, rs, rt, urs, urt, wr, we, ld, 0);
    while (last_st && n < 3) begin
      cyc(1, 1, rs, rt, urs, urt, wr, we, ld, 0);
      n++;
    end
  endtask

  task automatic nop();
    cyc(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, want);
    end
  endtask

  // monitor: compare DUT against the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", stall, e.st);
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
        chk("wb_wreg", wb_wreg, e.wr);
        chk("wb_we", wb_we, e.we);
      end
    end
  end

  initial begin
    rstd = 0; id_valid = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; id_wreg = 0;
    id_we = 0; id_load = 0; flush = 0;
    m_reset();

    // reset with random inputs
    repeat (4)
      cyc(0, 1'($urandom), 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    nop();

    // ALU hazard at distances 1..4
    for (int g = 0; g < 4; g++) begin
      ins(5'd8, 1, 0, 5'd0, 0, 5'd0, 0);
      repeat (g) nop();
      ins(5'd10, 1, 0, 5'd8, 1, 5'd1, 1);
      repeat (4) nop();
    end

    // load-use
    ins(5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd11, 1, 0, 5'd2, 1, 5'd9, 1);
    repeat (4) nop();

    // $zero
    ins(5'd0, 1, 0, 5'd0, 0, 5'd0, 0);
    ins(5'd12, 1, 0, 5'd0, 1, 5'd0, 1);
    ins(5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd13, 1, 0, 5'd0, 1, 5'd0, 1);
    repeat (4) nop();

    // priority, same register on both operands
    ins(5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
    ins(5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
    ins(5'd14, 1, 0, 5'd5, 1, 5'd5, 1);
    repeat (4) nop();

    // flush over load-use
    ins(5'd6, 1, 1, 5'd0, 0, 5'd0, 0);
    cyc(1, 1, 5'd6, 5'd6, 1, 1, 5'd15, 1, 0, 1);
    repeat (4) nop();

    // write-back sequence
    ins(5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
    ins(5'd4, 1, 0, 5'd0, 0, 5'd0, 0);
    cyc(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    repeat (4) nop();

    // asynchronous reset mid-stream
    ins(5'd7, 1, 1, 5'd0, 0, 5'd0, 0);
    ins(5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    ins(5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    cyc(0, 1, 5'd7, 5'd7, 1, 1, 5'd7, 1, 0, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);

    // random stream over a small register set
    for (int i = 0; i < 300; i++) begin
      if (last_st)
        cyc(1, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
            id_wreg, id_we, id_load, ($urandom_range(0, 9) == 0));
      else
        cyc(1, ($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
